// File: rtl/multi_channel_delay_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | multi_channel_delay_unit_pkg: shared defaults and helper functions         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package multi_channel_delay_unit_pkg;

  localparam int DEFAULT_N_CH    = 2;
  localparam int DEFAULT_DATA_W  = 5;
  localparam int DEFAULT_DEPTH   = 3;
  localparam bit DEFAULT_REVERSE = 1'b1;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Output port driven by the pipeline that input j feeds.
  function automatic int route(input int j, input int n_ch, input bit reverse);
    return reverse ? (n_ch - 1 - j) : j;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_channel_delay_unit_delay_lane.sv
// +----------------------------------------------------------------------------+
// | delay_lane: one DATA_W x DEPTH stallable pipeline with occupancy count     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module delay_lane
  import multi_channel_delay_unit_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int CW     = occ_width(DEFAULT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     occ
);

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  v_prev;
  logic [DEPTH-1:0]  adv;
  logic              hold;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] d      [DEPTH];
  logic [DATA_W-1:0] d_prev [DEPTH];

  // A stage holds only when it and every stage downstream are full and the
  // consumer is stalled; otherwise the bubble ahead lets it advance.
  always_comb begin
    hold = !out_ready;
    adv  = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      hold   = hold && v[s];
      adv[s] = !hold;
    end
  end

  always_comb begin
    cnt = '0;
    for (int s = 0; s < DEPTH; s++) begin
      cnt = cnt + CW'(v[s]);
    end
  end

  assign v_prev = DEPTH'({v, in_valid});

  for (genvar s = 0; s < DEPTH; s++) begin : g_dprev
    if (s == 0) begin : g_head
      assign d_prev[s] = in_data;
    end else begin : g_body
      assign d_prev[s] = d[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        if (adv[s]) v[s] <= v_prev[s];
      end
    end
  end

  // Payload carries no reset; it is only meaningful alongside v.
  always_ff @(posedge clk) begin
    for (int s = 0; s < DEPTH; s++) begin
      if (adv[s]) d[s] <= d_prev[s];
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign occ       = cnt;

endmodule

`default_nettype wire

// File: rtl/multi_channel_delay_unit.sv
// +----------------------------------------------------------------------------+
// | multi_channel_delay_unit: N-channel elastic delay line with routing.       |
// | Optional SVA via MULTI_CHANNEL_DELAY_UNIT_ASSERT_EN.  Rev 1.0              |
// +----------------------------------------------------------------------------+
`default_nettype none

module multi_channel_delay_unit
  import multi_channel_delay_unit_pkg::*;
#(
  parameter int N_CH    = DEFAULT_N_CH,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter bit REVERSE = DEFAULT_REVERSE
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [N_CH*DATA_W-1:0]              I_data,
  input  logic [N_CH-1:0]                     I_valid,
  output logic [N_CH-1:0]                     I_ready,
  output logic [N_CH*DATA_W-1:0]              O_data,
  output logic [N_CH-1:0]                     O_valid,
  input  logic [N_CH-1:0]                     O_ready,
  output logic [N_CH*occ_width(DEPTH)-1:0]    OCC
);

  localparam int CW = occ_width(DEPTH);

  for (genvar j = 0; j < N_CH; j++) begin : g_lane
    localparam int K = route(j, N_CH, REVERSE);

    delay_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CW     (CW)
    ) u_lane (
      .clk       (CLK),
      .rst       (RESET),
      .in_data   (I_data[j*DATA_W +: DATA_W]),
      .in_valid  (I_valid[j]),
      .in_ready  (I_ready[j]),
      .out_data  (O_data[K*DATA_W +: DATA_W]),
      .out_valid (O_valid[K]),
      .out_ready (O_ready[K]),
      .occ       (OCC[K*CW +: CW])
    );

`ifdef MULTI_CHANNEL_DELAY_UNIT_ASSERT_EN
    a_stable : assert property (@(posedge CLK) disable iff (RESET)
      O_valid[K] && !O_ready[K] |=> O_valid[K] && $stable(O_data[K*DATA_W +: DATA_W]));

    a_occ_max : assert property (@(posedge CLK) disable iff (RESET)
      OCC[K*CW +: CW] <= CW'(DEPTH));

    if (DEPTH == 1) begin : g_lat_one
      a_latency : assert property (@(posedge CLK) disable iff (RESET)
        I_valid[j] && I_ready[j] |=> O_valid[K]);
    end else begin : g_lat_multi
      a_latency : assert property (@(posedge CLK) disable iff (RESET)
        (I_valid[j] && I_ready[j]) ##1 (O_ready[K] [*(DEPTH-1)]) |=> O_valid[K]);
    end
`endif
  end

endmodule

`default_nettype wire
